// File: rtl/param_datapath.sv
// rtl/param_datapath.sv - register-file / RAM / ALU datapath with a 4-state command FSM
// Optional status flags are enabled by defining PARAM_DATAPATH_FLAGS_EN.
module param_datapath #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 4,
  parameter int D_AW   = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Cmd_valid,
  output logic              Cmd_ready,
  input  logic [1:0]        Cmd_op,
  input  logic [2:0]        ALU_s0,
  input  logic [RF_AW-1:0]  RF_W_Addr,
  input  logic [RF_AW-1:0]  RF_Ra_Addr,
  input  logic [RF_AW-1:0]  RF_Rb_Addr,
  input  logic [D_AW-1:0]   D_Addr,
  output logic              Done,
  output logic [DATA_W-1:0] ALU_inA,
  output logic [DATA_W-1:0] ALU_inB,
  output logic [DATA_W-1:0] ALU_out,
  output logic [1:0]        Flags
);

  localparam int RF_N  = 1 << RF_AW;
  localparam int MEM_N = 1 << D_AW;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_ALU   = 2'd3;

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_e;

  state_e             state_q;
  logic               ready_q;
  logic               done_q;
  logic [1:0]         op_q;
  logic [2:0]         sel_q;
  logic [RF_AW-1:0]   w_q;
  logic [RF_AW-1:0]   ra_q;
  logic [RF_AW-1:0]   rb_q;
  logic [D_AW-1:0]    da_q;
  logic [DATA_W-1:0]  ina_q;
  logic [DATA_W-1:0]  inb_q;
  logic [DATA_W-1:0]  out_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [DATA_W-1:0]  rf_q  [RF_N];
  logic [DATA_W-1:0]  mem_q [MEM_N];

  logic [DATA_W-1:0]  opa;
  logic [DATA_W-1:0]  opb;
  logic [DATA_W-1:0]  alu_res;

  // Operands always come from the pre-write register contents, so W==Ra/Rb reads old values.
  assign opa = rf_q[ra_q];
  assign opb = rf_q[rb_q];

  always_comb begin
    alu_res = '0;
    case (sel_q)
      3'd0: alu_res = opa;
      3'd1: alu_res = opa + opb;
      3'd2: alu_res = opa - opb;
      3'd3: alu_res = opa & opb;
      3'd4: alu_res = opa | opb;
      3'd5: alu_res = opa ^ opb;
      3'd6: alu_res = ~opa;
      3'd7: alu_res = opa << 1;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      op_q    <= OP_NOP;
      sel_q   <= '0;
      w_q     <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      da_q    <= '0;
      ina_q   <= '0;
      inb_q   <= '0;
      out_q   <= '0;
      for (int i = 0; i < RF_N; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Cmd_valid && ready_q) begin
            op_q  <= Cmd_op;
            sel_q <= ALU_s0;
            w_q   <= RF_W_Addr;
            ra_q  <= RF_Ra_Addr;
            rb_q  <= RF_Rb_Addr;
            da_q  <= D_Addr;
            case (Cmd_op)
              OP_NOP: done_q <= 1'b1;
              OP_LOAD: begin
                state_q <= MEM;
                ready_q <= 1'b0;
              end
              OP_STORE, OP_ALU: begin
                state_q <= EXEC;
                ready_q <= 1'b0;
              end
            endcase
          end
        end
        EXEC: begin
          // For STORE the observed result is the word written to RAM.
          ina_q <= opa;
          inb_q <= opb;
          out_q <= (op_q == OP_ALU) ? alu_res : opa;
          if (op_q == OP_ALU) begin
            rf_q[w_q] <= alu_res;
          end
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
        MEM: begin
          state_q <= WB;
        end
        WB: begin
          rf_q[w_q] <= rdata_q;
          state_q   <= IDLE;
          ready_q   <= 1'b1;
          done_q    <= 1'b1;
        end
      endcase
    end
  end

  // RAM has no reset; a write is suppressed on any edge where reset is asserted.
  always_ff @(posedge Clock) begin
    rdata_q <= mem_q[da_q];
    if (Resetn && state_q == EXEC && op_q == OP_STORE) begin
      mem_q[da_q] <= opa;
    end
  end

`ifdef PARAM_DATAPATH_FLAGS_EN
  logic [DATA_W:0] sum_ext;
  logic            alu_carry;
  logic [1:0]      flags_q;

  assign sum_ext = {1'b0, opa} + {1'b0, opb};

  always_comb begin
    alu_carry = 1'b0;
    case (sel_q)
      3'd1: alu_carry = sum_ext[DATA_W];
      3'd2: alu_carry = (opa < opb);
      3'd7: alu_carry = opa[DATA_W-1];
      default: alu_carry = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      flags_q <= 2'b00;
    end else if (state_q == EXEC && op_q == OP_ALU) begin
      flags_q <= {(alu_res == '0), alu_carry};
    end
  end

  assign Flags = flags_q;
`else
  assign Flags = 2'b00;
`endif

  assign Cmd_ready = ready_q;
  assign Done      = done_q;
  assign ALU_inA   = ina_q;
  assign ALU_inB   = inb_q;
  assign ALU_out   = out_q;

endmodule
